// File: rtl/drone_cmd_pkg.sv
// Shared frame constants, command codes and parser state encoding for the
// ground-station command link; the flight-control block reuses the state type.
package drone_cmd_pkg;

   localparam logic [7:0] START_BYTE  = 8'h0A;
   localparam logic [7:0] STOP_BYTE   = 8'h08;
   localparam logic [7:0] CMD_MAX     = 8'h07;

   localparam logic [7:0] CMD_TAKEOFF = 8'h01;
   localparam logic [7:0] CMD_LAND    = 8'h02;
   localparam logic [7:0] CMD_HOVER   = 8'h03;
   localparam logic [7:0] CMD_FORWARD = 8'h04;
   localparam logic [7:0] CMD_BACK    = 8'h05;
   localparam logic [7:0] CMD_LEFT    = 8'h06;
   localparam logic [7:0] CMD_RIGHT   = 8'h07;

   localparam int unsigned TIMEOUT_CYC = 25000;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_CMD  = 2'd1,
      ST_WAIT_STOP = 2'd2
   } parser_state_e;

   function automatic logic is_legal_cmd(input logic [7:0] b);
      return (b >= CMD_TAKEOFF) && (b <= CMD_MAX);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return 8'hFF;
      end else begin
         return v + 8'h01;
      end
   endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Reloadable inter-byte timeout counter; expired_o is high on the last count
// before timeout, and the count returns to zero when disabled or expired.
module cmd_timeout_timer #(
   parameter int unsigned TIMEOUT_CYC = 25000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   input  logic reload_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired_o = (cnt_q == LAST_CNT);

   // Next count: expiry clears too, because the parser drops to IDLE on it.
   always_comb begin
      cnt_d = cnt_q;
      if (reload_i || !enable_i || expired_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Validates START/command/STOP frames from the UART receiver and issues
// registered command, frame-error and timeout strobes plus an error count.
module uart_cmd_parser
   import drone_cmd_pkg::*;
(
   input  logic       FCLK_CLK0_0,
   input  logic       FCLK_RESET0_N_0,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
   output logic       frame_err,
   output logic       timeout_err,
   output logic [7:0] err_cnt,
   output logic       busy
);

   parser_state_e state_q, state_d;
   logic [7:0] cmd_buf_q, cmd_code_q, err_cnt_q;
   logic       cmd_valid_q, frame_err_q, timeout_err_q, busy_q;
   logic       cmd_valid_d, frame_err_d, timeout_err_d, load_buf_d;
   logic       timer_en_s, timer_reload_s, timer_expired_s;

   assign timer_en_s     = (state_q != ST_IDLE);
   assign timer_reload_s = rx_valid && (state_q != ST_IDLE);

   cmd_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk_i     (FCLK_CLK0_0),
      .rst_ni    (FCLK_RESET0_N_0),
      .enable_i  (timer_en_s),
      .reload_i  (timer_reload_s),
      .expired_o (timer_expired_s)
   );

   // Frame decision; a byte arriving on the expiry cycle takes priority.
   always_comb begin
      state_d       = state_q;
      cmd_valid_d   = 1'b0;
      frame_err_d   = 1'b0;
      timeout_err_d = 1'b0;
      load_buf_d    = 1'b0;
      if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_data == START_BYTE) begin
                  state_d = ST_WAIT_CMD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_WAIT_CMD: begin
               if (rx_data == START_BYTE) begin
                  state_d = ST_WAIT_CMD;
               end else if (is_legal_cmd(rx_data)) begin
                  load_buf_d = 1'b1;
                  state_d    = ST_WAIT_STOP;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
            ST_WAIT_STOP: begin
               if (rx_data == STOP_BYTE) begin
                  cmd_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end else if (rx_data == START_BYTE) begin
                  frame_err_d = 1'b1;
                  state_d     = ST_WAIT_CMD;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (timer_expired_s && (state_q != ST_IDLE)) begin
         timeout_err_d = 1'b1;
         state_d       = ST_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // State and registered outputs; busy tracks the state being entered.
   always_ff @(posedge FCLK_CLK0_0) begin
      if (!FCLK_RESET0_N_0) begin
         state_q       <= ST_IDLE;
         cmd_buf_q     <= 8'h00;
         cmd_code_q    <= 8'h00;
         err_cnt_q     <= 8'h00;
         cmd_valid_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         busy_q        <= (state_d != ST_IDLE);
         cmd_valid_q   <= cmd_valid_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
         if (load_buf_d) begin
            cmd_buf_q <= rx_data;
         end
         if (cmd_valid_d) begin
            cmd_code_q <= cmd_buf_q;
         end
         if (frame_err_d || timeout_err_d) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
         end
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_code    = cmd_code_q;
   assign frame_err   = frame_err_q;
   assign timeout_err = timeout_err_q;
   assign err_cnt     = err_cnt_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a frame-level reference model queues
// expected strobes, and a negedge monitor pops and compares them.
module tb_uart_cmd_parser;

   localparam int TMO = 25000;
   localparam int BAUD_GAP = 4340;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       cmd_valid, frame_err, timeout_err, busy;
   logic [7:0] cmd_code, err_cnt;

   always #10 clk = ~clk;

   uart_cmd_parser dut (
      .FCLK_CLK0_0     (clk),
      .FCLK_RESET0_N_0 (rst_n),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .cmd_valid       (cmd_valid),
      .cmd_code        (cmd_code),
      .frame_err       (frame_err),
      .timeout_err     (timeout_err),
      .err_cnt         (err_cnt),
      .busy            (busy)
   );

   typedef struct {
      int         kind;   // 0 command, 1 frame error, 2 timeout
      logic [7:0] code;
      logic [7:0] errc;
      longint     due;
   } ev_t;

   ev_t        exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   longint     cyc = 0;
   bit         mon_en = 1'b0;

   // Reference model: the bytes of the frame currently open, plus idle gap.
   logic [7:0] frame_q[$];
   int         gap = 0;
   logic [7:0] m_code = 8'h00;
   logic [7:0] m_err = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push_ev(input int kind, input logic [7:0] code, input longint due);
      ev_t e;
      if (kind == 0) m_code = code;
      else if (m_err != 8'hFF) m_err = m_err + 8'd1;
      e.kind = kind;
      e.code = code;
      e.errc = m_err;
      e.due  = due;
      exp_q.push_back(e);
   endfunction

   function automatic void model(input bit r, input bit v, input logic [7:0] d, input longint k);
      if (!r) begin
         frame_q.delete();
         gap = 0;
         m_code = 8'h00;
         m_err = 8'h00;
      end else if (v) begin
         if (frame_q.size() == 0) begin
            if (d == 8'h0A) frame_q.push_back(d);
         end else if (frame_q.size() == 1) begin
            gap = 0;
            if (d >= 8'h01 && d <= 8'h07) frame_q.push_back(d);
            else if (d != 8'h0A) begin
               push_ev(1, 8'h00, k + 1);
               frame_q.delete();
            end
         end else begin
            gap = 0;
            if (d == 8'h08) begin
               push_ev(0, frame_q[1], k + 1);
               frame_q.delete();
            end else begin
               push_ev(1, 8'h00, k + 1);
               frame_q.delete();
               if (d == 8'h0A) frame_q.push_back(d);
            end
         end
      end else if (frame_q.size() != 0) begin
         gap++;
         if (gap == TMO) begin
            push_ev(2, 8'h00, k + 1);
            frame_q.delete();
            gap = 0;
         end
      end
   endfunction

   task automatic step(input bit r, input bit v, input logic [7:0] d);
      rst_n = r;
      rx_valid = v;
      rx_data = d;
      @(posedge clk);
      model(r, v, d, cyc);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Monitor: pops the scoreboard whenever a strobe is due or appears.
   always @(negedge clk) begin
      if (mon_en) begin
         int   act_kind;
         ev_t  e;
         bit   any_s;
         any_s = cmd_valid || frame_err || timeout_err;
         act_kind = cmd_valid ? 0 : (frame_err ? 1 : 2);
         if (any_s) begin
            n_cmp++;
            if ($countones({cmd_valid, frame_err, timeout_err}) != 1) begin
               n_bad++;
               $display("FAIL strobes: cv=%0b fe=%0b te=%0b at cycle %0d", cmd_valid, frame_err, timeout_err, cyc);
            end else if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
               n_bad++;
               $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected", act_kind, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.kind != act_kind || (e.kind == 0 && cmd_code !== e.code) || err_cnt !== e.errc) begin
                  n_bad++;
                  $display("FAIL event: got kind %0d code %0h errc %0h, expected kind %0d code %0h errc %0h",
                           act_kind, cmd_code, err_cnt, e.kind, e.code, e.errc);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            n_cmp++;
            n_bad++;
            e = exp_q.pop_front();
            $display("FAIL missed_strobe: got none at cycle %0d, expected kind %0d", cyc, e.kind);
         end
         n_cmp++;
         if (busy !== (frame_q.size() != 0) || cmd_code !== m_code || err_cnt !== m_err) begin
            n_bad++;
            $display("FAIL state: got busy %0b code %0h errc %0h, expected busy %0b code %0h errc %0h at cycle %0d",
                     busy, cmd_code, err_cnt, (frame_q.size() != 0), m_code, m_err, cyc);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      step(1'b1, 1'b1, b);
   endtask

   initial begin
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      mon_en = 1'b1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_code", {24'd0, cmd_code}, 32'd0);
      chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("reset_strobes", {29'd0, cmd_valid, frame_err, timeout_err}, 32'd0);

      // Legal frame at UART byte spacing.
      send(8'h0A); idle(BAUD_GAP);
      send(8'h04); idle(BAUD_GAP);
      send(8'h08);
      chk("legal_cv", {31'd0, cmd_valid}, 32'd1);
      chk("legal_code", {24'd0, cmd_code}, 32'h04);
      chk("legal_busy", {31'd0, busy}, 32'd0);
      chk("legal_errc", {24'd0, err_cnt}, 32'd0);
      idle(3);

      // Illegal command, then a stray STOP.
      send(8'h0A); send(8'h09);
      chk("illegal_fe", {31'd0, frame_err}, 32'd1);
      chk("illegal_errc", {24'd0, err_cnt}, 32'd1);
      send(8'h08);
      chk("illegal_no_cv", {31'd0, cmd_valid}, 32'd0);
      chk("illegal_code_held", {24'd0, cmd_code}, 32'h04);
      idle(2);

      // Resync cases.
      send(8'h0A); send(8'h0A); send(8'h01); send(8'h08);
      chk("resync1_code", {24'd0, cmd_code}, 32'h01);
      chk("resync1_errc", {24'd0, err_cnt}, 32'd1);
      idle(2);
      send(8'h0A); send(8'h02); send(8'h0A);
      chk("resync2_fe", {31'd0, frame_err}, 32'd1);
      send(8'h03); send(8'h08);
      chk("resync2_code", {24'd0, cmd_code}, 32'h03);
      idle(2);

      // Timeout exactly TMO cycles after the START byte.
      send(8'h0A); idle(TMO - 1);
      chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
      chk("tmo_busy_before", {31'd0, busy}, 32'd1);
      idle(1);
      chk("tmo_fire", {31'd0, timeout_err}, 32'd1);
      chk("tmo_idle", {31'd0, busy}, 32'd0);
      idle(2);

      // Byte landing on the expiry cycle wins over the timeout.
      send(8'h0A); idle(TMO - 1); send(8'h05);
      chk("tmo_race_none", {31'd0, timeout_err}, 32'd0);
      chk("tmo_race_busy", {31'd0, busy}, 32'd1);
      send(8'h08);
      chk("tmo_race_code", {24'd0, cmd_code}, 32'h05);
      idle(2);

      // Saturation of the error counter.
      for (int i = 0; i < 300; i++) begin
         send(8'h0A); send(8'h00); idle(1);
      end
      chk("sat_errc", {24'd0, err_cnt}, 32'hFF);

      // Reset mid-frame, then a STOP that must produce nothing.
      send(8'h0A); send(8'h05);
      step(1'b0, 1'b0, 8'h00);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_code", {24'd0, cmd_code}, 32'd0);
      chk("midrst_errc", {24'd0, err_cnt}, 32'd0);
      send(8'h08);
      chk("midrst_no_cv", {31'd0, cmd_valid}, 32'd0);
      idle(2);

      // Back-to-back bytes.
      send(8'h0A); send(8'h06); send(8'h08);
      chk("b2b_cv", {31'd0, cmd_valid}, 32'd1);
      chk("b2b_code", {24'd0, cmd_code}, 32'h06);

      // Randomized byte stream with short gaps.
      for (int i = 0; i < 600; i++) begin
         int unsigned r;
         logic [7:0]  b;
         r = $urandom_range(0, 9);
         if (r <= 2) b = 8'h0A;
         else if (r <= 5) b = 8'($urandom_range(1, 7));
         else if (r <= 7) b = 8'h08;
         else if (r == 8) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h09;
         else b = 8'($urandom_range(0, 255));
         send(b);
         idle(int'($urandom_range(0, 6)));
      end
      idle(4);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_events: got %0d pending, expected 0", exp_q.size());
      end
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
